// File: rtl/keypad_pkg.sv
// keypad_pkg: shared matrix geometry, code width and debounce state type for the keypad scanner.
package keypad_pkg;
  localparam int ROWS   = 4;
  localparam int COLS   = 4;
  localparam int CODE_W = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONFIRM = 2'd1,
    HELD    = 2'd2,
    RELEASE = 2'd3
  } key_state_e;

  // Lowest-index column pulled low; only meaningful when at least one column is low.
  function automatic logic [1:0] lowest_low_col(input logic [COLS-1:0] cols);
    logic [1:0] idx;
    idx = 2'd0;
    for (int c = COLS - 1; c >= 0; c--) begin
      if (!cols[c]) idx = 2'(c);
    end
    return idx;
  endfunction
endpackage

// File: rtl/keypad_scan_col_sync.sv
// col_sync: two-flop synchronizer for the asynchronous column returns; resets to all-ones (no key).
module col_sync
  import keypad_pkg::*;
(
  input  logic            clk_i,
  input  logic            resetn_i,
  input  logic [COLS-1:0] col_i,
  output logic [COLS-1:0] col_o
);
  logic [COLS-1:0] meta_q;
  logic [COLS-1:0] sync_q;

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      meta_q <= '1;
      sync_q <= '1;
    end else begin
      meta_q <= col_i;
      sync_q <= meta_q;
    end
  end

  assign col_o = sync_q;
endmodule

// File: rtl/keypad_scan.sv
// keypad_scan: 4x4 matrix keypad scanner with whole-frame debounce and a valid/ack event register.
// Optional auto-repeat while a key stays held is enabled by defining KEYPAD_SCAN_REPEAT_EN.
module keypad_scan
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 16384,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int REPEAT_SCANS   = 64
) (
  input  logic              clk,
  input  logic              resetn,
  output logic [ROWS-1:0]   row_out,
  input  logic [COLS-1:0]   col_in,
  output logic [CODE_W-1:0] key_code,
  output logic              key_valid,
  input  logic              key_ack,
  output logic              key_held,
  output logic              overrun
);
  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_SCANS);

  if (SCAN_DIV < 4 || DEBOUNCE_SCANS < 1 || REPEAT_SCANS < 1) begin : g_bad_params
    $error("keypad_scan: parameter out of range");
  end

  logic [COLS-1:0]   colSync;
  logic [DIV_W-1:0]  div_q;
  logic [1:0]        rowIdx_q;
  logic [ROWS-1:0]   rowOut_q;
  logic              accFound_q;
  logic [CODE_W-1:0] accCode_q;
  logic              frameDone_q;
  logic              frameFound_q;
  logic [CODE_W-1:0] frameCode_q;
  logic              rowHit;
  logic [CODE_W-1:0] rowHitCode;

  key_state_e        state_q, state_d;
  logic [CODE_W-1:0] cand_q, cand_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  cntInc;
  logic              keyMatch;
  logic              newPress;
  logic              heldMatch;
  logic              accept;

  logic [CODE_W-1:0] keyCode_q, keyCode_d;
  logic              keyValid_q, keyValid_d;
  logic              overrun_q, overrun_d;

  col_sync u_col_sync (
    .clk_i   (clk),
    .resetn_i(resetn),
    .col_i   (col_in),
    .col_o   (colSync)
  );

  // Earlier rows win, so the accumulator keeps the first hit of the frame.
  always_comb begin
    rowHit     = accFound_q | (colSync != '1);
    rowHitCode = accFound_q ? accCode_q : {rowIdx_q, lowest_low_col(colSync)};
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      div_q        <= '0;
      rowIdx_q     <= 2'd0;
      rowOut_q     <= 4'b1110;
      accFound_q   <= 1'b0;
      accCode_q    <= '0;
      frameDone_q  <= 1'b0;
      frameFound_q <= 1'b0;
      frameCode_q  <= '0;
    end else begin
      frameDone_q <= 1'b0;
      if (div_q == DIV_LAST) begin
        div_q    <= '0;
        rowIdx_q <= rowIdx_q + 2'd1;
        rowOut_q <= {rowOut_q[ROWS-2:0], rowOut_q[ROWS-1]};
        if (rowIdx_q == 2'd3) begin
          frameDone_q  <= 1'b1;
          frameFound_q <= rowHit;
          frameCode_q  <= rowHitCode;
          accFound_q   <= 1'b0;
          accCode_q    <= '0;
        end else begin
          accFound_q <= rowHit;
          accCode_q  <= rowHitCode;
        end
      end else begin
        div_q <= div_q + DIV_W'(1);
      end
    end
  end

  // Debounce FSM advances only on the cycle after a completed frame.
  always_comb begin
    state_d   = state_q;
    cand_d    = cand_q;
    cnt_d     = cnt_q;
    newPress  = 1'b0;
    heldMatch = 1'b0;
    keyMatch  = frameFound_q && (frameCode_q == cand_q);
    cntInc    = cnt_q + CNT_W'(1);
    if (frameDone_q) begin
      case (state_q)
        IDLE: begin
          if (frameFound_q) begin
            cand_d = frameCode_q;
            if (DEBOUNCE_SCANS == 1) begin
              state_d  = HELD;
              cnt_d    = '0;
              newPress = 1'b1;
            end else begin
              state_d = CONFIRM;
              cnt_d   = CNT_W'(1);
            end
          end
        end
        CONFIRM: begin
          if (!frameFound_q) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else if (keyMatch) begin
            if (cntInc == CNT_DONE) begin
              state_d  = HELD;
              cnt_d    = '0;
              newPress = 1'b1;
            end else begin
              cnt_d = cntInc;
            end
          end else begin
            cand_d = frameCode_q;
            cnt_d  = CNT_W'(1);
          end
        end
        HELD: begin
          if (keyMatch) begin
            heldMatch = 1'b1;
          end else if (DEBOUNCE_SCANS == 1) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            state_d = RELEASE;
            cnt_d   = CNT_W'(1);
          end
        end
        RELEASE: begin
          if (keyMatch) begin
            state_d = HELD;
            cnt_d   = '0;
          end else if (cntInc == CNT_DONE) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cntInc;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      cand_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef KEYPAD_SCAN_REPEAT_EN
  localparam int RPT_W = $clog2(REPEAT_SCANS + 1);
  localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_SCANS);

  logic [RPT_W-1:0] rpt_q, rpt_d;
  logic             repeatFire;

  // Only a fresh press restarts the repeat period; bouncing back from RELEASE keeps it.
  always_comb begin
    rpt_d      = rpt_q;
    repeatFire = 1'b0;
    if (newPress) begin
      rpt_d = '0;
    end else if (heldMatch) begin
      if (rpt_q + RPT_W'(1) == RPT_LAST) begin
        rpt_d      = '0;
        repeatFire = 1'b1;
      end else begin
        rpt_d = rpt_q + RPT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) rpt_q <= '0;
    else         rpt_q <= rpt_d;
  end

  assign accept = newPress | repeatFire;
`else
  assign accept = newPress;
`endif

  always_comb begin
    keyCode_d  = keyCode_q;
    keyValid_d = keyValid_q;
    overrun_d  = overrun_q;
    if (accept && (!keyValid_q || key_ack)) begin
      keyCode_d  = frameCode_q;
      keyValid_d = 1'b1;
      overrun_d  = 1'b0;
    end else if (accept) begin
      overrun_d = 1'b1;
    end else if (key_ack && keyValid_q) begin
      keyValid_d = 1'b0;
      overrun_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      keyCode_q  <= '0;
      keyValid_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      keyCode_q  <= keyCode_d;
      keyValid_q <= keyValid_d;
      overrun_q  <= overrun_d;
    end
  end

  assign row_out   = rowOut_q;
  assign key_code  = keyCode_q;
  assign key_valid = keyValid_q;
  assign key_held  = (state_q == HELD) || (state_q == RELEASE);
  assign overrun   = overrun_q;
endmodule
